// File: rtl/matrix_store_pkg.sv
// Shared definitions for the matrix storage controller: default sizing,
// FSM state encoding, source-select encoding and a dimension check helper.
package matrix_store_pkg;

   localparam int MAX_SIZE_DEF            = 5;
   localparam int MATRIX_NUM_DEF          = 8;
   localparam int MAX_MATRIX_PER_SIZE_DEF = 4;

   localparam int DIM_W = 3;   // row/col field width
   localparam int IDX_W = 4;   // slot index width on the write port
   localparam int AGE_W = 3;   // per-slot saturating age

   localparam logic [AGE_W-1:0] AGE_MAX = 3'd7;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ALLOC = 2'd1,
      ST_WRITE = 2'd2,
      ST_ACK   = 2'd3
   } state_e;

   // Data-mux select: which producer's matrix is being stored.
   typedef enum logic {
      SRC_MAN = 1'b0,
      SRC_RND = 1'b1
   } src_e;

   // A dimension is legal when it lies in 1..max_size.
   function automatic logic dim_legal(input logic [DIM_W-1:0] d, input int max_size);
      return (d != '0) && (int'(d) <= max_size);
   endfunction

endpackage

// File: rtl/matrix_slot_alloc.sv
// Combinational victim selection for the matrix store.
// Priority: oldest slot of the requested scale once that scale is at its
// per-scale limit, otherwise the lowest free slot, otherwise the globally
// oldest slot. Age ties always go to the lowest index.
module matrix_slot_alloc
   import matrix_store_pkg::*;
#(
   parameter int MATRIX_NUM          = MATRIX_NUM_DEF,
   parameter int MAX_MATRIX_PER_SIZE = MAX_MATRIX_PER_SIZE_DEF
) (
   input  logic [MATRIX_NUM-1:0]            valid_i,
   input  logic [MATRIX_NUM-1:0][DIM_W-1:0] row_tag_i,
   input  logic [MATRIX_NUM-1:0][DIM_W-1:0] col_tag_i,
   input  logic [MATRIX_NUM-1:0][AGE_W-1:0] age_i,
   input  logic [DIM_W-1:0]                 req_row_i,
   input  logic [DIM_W-1:0]                 req_col_i,
   output logic [IDX_W-1:0]                 target_idx_o
);

   localparam int CNT_W = $clog2(MATRIX_NUM + 1);

   logic             same_found;
   logic             free_found;
   logic [IDX_W-1:0] same_idx;
   logic [IDX_W-1:0] free_idx;
   logic [IDX_W-1:0] old_idx;
   logic [AGE_W-1:0] same_age;
   logic [AGE_W-1:0] old_age;
   logic [CNT_W-1:0] scale_cnt;

   // Scan all slots once: same-scale count and oldest, first free, global oldest.
   always_comb begin
      same_found = 1'b0;
      free_found = 1'b0;
      same_idx   = '0;
      free_idx   = '0;
      old_idx    = '0;
      same_age   = '0;
      old_age    = '0;
      scale_cnt  = '0;
      for (int i = 0; i < MATRIX_NUM; i++) begin
         if (valid_i[i] && (row_tag_i[i] == req_row_i) && (col_tag_i[i] == req_col_i)) begin
            scale_cnt = scale_cnt + CNT_W'(1);
            // Strictly-greater keeps the lowest index on an age tie.
            if (!same_found || (age_i[i] > same_age)) begin
               same_found = 1'b1;
               same_idx   = IDX_W'(i);
               same_age   = age_i[i];
            end
         end
         if (!valid_i[i] && !free_found) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
         if ((i == 0) || (age_i[i] > old_age)) begin
            old_idx = IDX_W'(i);
            old_age = age_i[i];
         end
      end
   end

   // Apply the victim priority.
   always_comb begin
      if (int'(scale_cnt) >= MAX_MATRIX_PER_SIZE) begin
         target_idx_o = same_idx;
      end else if (free_found) begin
         target_idx_o = free_idx;
      end else begin
         target_idx_o = old_idx;
      end
   end

endmodule

// File: rtl/matrix_store_ctrl.sv
// Write controller for a small matrix store shared by a manual-input path
// and a random-generator path. Arbitrates round-robin, checks dimensions,
// picks a victim slot, issues one write and acknowledges the source.
// Optional feature: define MATRIX_STORE_CTRL_CLEAR_EN to add a clr input
// that empties the store (applied while idle, deferred otherwise).
// Handshake: req_* is a level held by the source until its grant_* pulse;
// the controller samples requests only in IDLE, so a source that keeps its
// request high after a grant is treated as a new request.
module matrix_store_ctrl
   import matrix_store_pkg::*;
#(
   parameter int MAX_SIZE            = MAX_SIZE_DEF,
   parameter int MATRIX_NUM          = MATRIX_NUM_DEF,
   parameter int MAX_MATRIX_PER_SIZE = MAX_MATRIX_PER_SIZE_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
`ifdef MATRIX_STORE_CTRL_CLEAR_EN
   input  logic             clr,
`endif
   input  logic             req_man,
   input  logic             req_rnd,
   input  logic [DIM_W-1:0] man_row,
   input  logic [DIM_W-1:0] man_col,
   input  logic [DIM_W-1:0] rnd_row,
   input  logic [DIM_W-1:0] rnd_col,
   output logic             grant_man,
   output logic             grant_rnd,
   output logic             wr_en,
   output logic [IDX_W-1:0] target_idx,
   output logic [DIM_W-1:0] write_row,
   output logic [DIM_W-1:0] write_col,
   output logic             sel_src,
   output logic             err_dim,
   output logic             busy,
   output logic             full,
   input  logic [DIM_W-1:0] q_row,
   input  logic [DIM_W-1:0] q_col,
   output logic [2:0]       q_cnt,
   output logic [1:0]       dbg_state
);

   localparam int CNT_W = $clog2(MATRIX_NUM + 1);

   state_e           state_q, state_d;
   src_e             src_q, src_d;
   src_e             last_q, last_d;
   logic [DIM_W-1:0] row_q, row_d;
   logic [DIM_W-1:0] col_q, col_d;
   logic [IDX_W-1:0] target_q, target_d;

   logic [MATRIX_NUM-1:0]            valid_q;
   logic [MATRIX_NUM-1:0][DIM_W-1:0] row_tag_q;
   logic [MATRIX_NUM-1:0][DIM_W-1:0] col_tag_q;
   logic [MATRIX_NUM-1:0][AGE_W-1:0] age_q;

   logic             dim_ok;
   logic [IDX_W-1:0] alloc_idx;
   logic [CNT_W-1:0] q_cnt_w;
   logic             clr_now;

   assign dim_ok = dim_legal(row_q, MAX_SIZE) && dim_legal(col_q, MAX_SIZE);

   matrix_slot_alloc #(
      .MATRIX_NUM          (MATRIX_NUM),
      .MAX_MATRIX_PER_SIZE (MAX_MATRIX_PER_SIZE)
   ) u_alloc (
      .valid_i      (valid_q),
      .row_tag_i    (row_tag_q),
      .col_tag_i    (col_tag_q),
      .age_i        (age_q),
      .req_row_i    (row_q),
      .req_col_i    (col_q),
      .target_idx_o (alloc_idx)
   );

   // Control registers; reset leaves the pointer so manual wins the first tie.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         src_q    <= SRC_MAN;
         last_q   <= SRC_RND;
         row_q    <= '0;
         col_q    <= '0;
         target_q <= '0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         last_q   <= last_d;
         row_q    <= row_d;
         col_q    <= col_d;
         target_q <= target_d;
      end
   end

   // Next-state logic, request latching and the per-state output pulses.
   always_comb begin
      state_d   = state_q;
      src_d     = src_q;
      last_d    = last_q;
      row_d     = row_q;
      col_d     = col_q;
      target_d  = target_q;
      wr_en     = 1'b0;
      grant_man = 1'b0;
      grant_rnd = 1'b0;
      err_dim   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_man || req_rnd) begin
               if (req_man && req_rnd) begin
                  src_d = (last_q == SRC_MAN) ? SRC_RND : SRC_MAN;
               end else if (req_rnd) begin
                  src_d = SRC_RND;
               end else begin
                  src_d = SRC_MAN;
               end
               row_d   = (src_d == SRC_RND) ? rnd_row : man_row;
               col_d   = (src_d == SRC_RND) ? rnd_col : man_col;
               state_d = ST_ALLOC;
            end
         end
         ST_ALLOC: begin
            if (!dim_ok) begin
               // Reject: error and grant pulse together, nothing is written.
               err_dim   = 1'b1;
               grant_man = (src_q == SRC_MAN);
               grant_rnd = (src_q == SRC_RND);
               last_d    = src_q;
               state_d   = ST_IDLE;
            end else begin
               target_d = alloc_idx;
               state_d  = ST_WRITE;
            end
         end
         ST_WRITE: begin
            wr_en   = 1'b1;
            state_d = ST_ACK;
         end
         ST_ACK: begin
            grant_man = (src_q == SRC_MAN);
            grant_rnd = (src_q == SRC_RND);
            last_d    = src_q;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

`ifdef MATRIX_STORE_CTRL_CLEAR_EN
   logic clr_pend_q;

   assign clr_now = (state_q == ST_IDLE) && (clr || clr_pend_q);

   // Remember a clear that arrives mid-transaction until the FSM is idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_pend_q <= 1'b0;
      end else if (clr_now) begin
         clr_pend_q <= 1'b0;
      end else if (clr) begin
         clr_pend_q <= 1'b1;
      end
   end
`else
   assign clr_now = 1'b0;
`endif

   // Slot table: tags and ages change only on the write edge or a clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q   <= '0;
         row_tag_q <= '0;
         col_tag_q <= '0;
         age_q     <= '0;
      end else if (state_q == ST_WRITE) begin
         for (int i = 0; i < MATRIX_NUM; i++) begin
            if (IDX_W'(i) == target_q) begin
               valid_q[i]   <= 1'b1;
               row_tag_q[i] <= row_q;
               col_tag_q[i] <= col_q;
               age_q[i]     <= '0;
            end else if (valid_q[i] && (age_q[i] != AGE_MAX)) begin
               age_q[i] <= age_q[i] + AGE_W'(1);
            end
         end
      end else if (clr_now) begin
         valid_q   <= '0;
         row_tag_q <= '0;
         col_tag_q <= '0;
         age_q     <= '0;
      end
   end

   // Query port: number of valid slots currently holding scale (q_row,q_col).
   always_comb begin
      q_cnt_w = '0;
      for (int i = 0; i < MATRIX_NUM; i++) begin
         if (valid_q[i] && (row_tag_q[i] == q_row) && (col_tag_q[i] == q_col)) begin
            q_cnt_w = q_cnt_w + CNT_W'(1);
         end
      end
   end

   assign q_cnt      = 3'(q_cnt_w);
   assign target_idx = (state_q == ST_WRITE) ? target_q : '0;
   assign write_row  = (state_q == ST_WRITE) ? row_q : '0;
   assign write_col  = (state_q == ST_WRITE) ? col_q : '0;
   assign sel_src    = src_q;
   assign busy       = (state_q != ST_IDLE);
   assign full       = &valid_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_matrix_store_ctrl.sv
// Bench for matrix_store_ctrl: directed vector table, hand sequences for
// arbitration, input latching and mid-write reset, then randomized traffic
// checked against a slot-level model of the store.
module tb_matrix_store_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_man = 1'b0, req_rnd = 1'b0;
   logic [2:0] man_row = '0, man_col = '0, rnd_row = '0, rnd_col = '0;
   logic       grant_man, grant_rnd, wr_en, sel_src, err_dim, busy, full;
   logic [3:0] target_idx;
   logic [2:0] write_row, write_col;
   logic [2:0] q_row = '0, q_col = '0;
   logic [2:0] q_cnt;
   logic [1:0] dbg_state;

   matrix_store_ctrl dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req_man    (req_man),
      .req_rnd    (req_rnd),
      .man_row    (man_row),
      .man_col    (man_col),
      .rnd_row    (rnd_row),
      .rnd_col    (rnd_col),
      .grant_man  (grant_man),
      .grant_rnd  (grant_rnd),
      .wr_en      (wr_en),
      .target_idx (target_idx),
      .write_row  (write_row),
      .write_col  (write_col),
      .sel_src    (sel_src),
      .err_dim    (err_dim),
      .busy       (busy),
      .full       (full),
      .q_row      (q_row),
      .q_col      (q_col),
      .q_cnt      (q_cnt),
      .dbg_state  (dbg_state)
   );

   // Clock and watchdog
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   int n_checks = 0;
   int n_errors = 0;

   // Observations from the most recent transaction.
   int         g_cyc, w_cyc, e_cyc;
   logic       g_man, g_rnd, w_sel;
   logic [3:0] w_tgt;
   logic [2:0] w_row, w_col;
   int         grant_log[$];

   // Reference model: slot contents, ages and last served source (0=man, 1=rnd).
   int m_valid[8];
   int m_row[8];
   int m_col[8];
   int m_age[8];
   int m_last;

   typedef struct {
      bit rst;
      bit src;
      int row;
      int col;
      bit exp_err;
      int exp_tgt;
      int exp_cnt;
      bit exp_full;
   } vec_t;

   vec_t tbl[18];

   task automatic chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      for (int i = 0; i < 8; i++) begin
         m_valid[i] = 0;
         m_row[i]   = 0;
         m_col[i]   = 0;
         m_age[i]   = 0;
      end
      m_last = 1;
   endfunction

   function automatic int model_cnt(input int r, input int c);
      int n = 0;
      for (int i = 0; i < 8; i++)
         if (m_valid[i] != 0 && m_row[i] == r && m_col[i] == c) n++;
      return n;
   endfunction

   function automatic int model_oldest(input int r, input int c, input bit any_scale);
      int best = -1;
      for (int i = 0; i < 8; i++) begin
         if (m_valid[i] != 0 && (any_scale || (m_row[i] == r && m_col[i] == c))) begin
            if (best < 0 || m_age[i] > m_age[best]) best = i;
         end
      end
      return best;
   endfunction

   function automatic int model_target(input int r, input int c);
      if (model_cnt(r, c) >= 4) return model_oldest(r, c, 1'b0);
      for (int i = 0; i < 8; i++)
         if (m_valid[i] == 0) return i;
      return model_oldest(0, 0, 1'b1);
   endfunction

   function automatic void model_write(input int t, input int r, input int c);
      for (int i = 0; i < 8; i++)
         if (i != t && m_valid[i] != 0 && m_age[i] < 7) m_age[i]++;
      m_valid[t] = 1;
      m_row[t]   = r;
      m_col[t]   = c;
      m_age[t]   = 0;
   endfunction

   function automatic int model_full();
      for (int i = 0; i < 8; i++)
         if (m_valid[i] == 0) return 0;
      return 1;
   endfunction

   // Reset with all inputs idle and confirm the reset-state outputs.
   task automatic do_reset();
      rst_n   = 1'b0;
      req_man = 1'b0;
      req_rnd = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      q_row = 3'd2;
      q_col = 3'd3;
      #1;
      chk("rst_wr_en", wr_en, 0);
      chk("rst_grant_man", grant_man, 0);
      chk("rst_grant_rnd", grant_rnd, 0);
      chk("rst_err_dim", err_dim, 0);
      chk("rst_busy", busy, 0);
      chk("rst_full", full, 0);
      chk("rst_target_idx", target_idx, 0);
      chk("rst_sel_src", sel_src, 0);
      chk("rst_q_cnt", q_cnt, 0);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // Observe posedges numbered from 'start' until a grant or the budget runs out.
   task automatic watch(input int start);
      g_cyc = -1; w_cyc = -1; e_cyc = -1;
      g_man = 1'b0; g_rnd = 1'b0; w_sel = 1'b0;
      w_tgt = '0; w_row = '0; w_col = '0;
      for (int c = start; c <= 8; c++) begin
         @(posedge clk);
         #1;
         if (wr_en) begin
            w_cyc = c;
            w_tgt = target_idx;
            w_row = write_row;
            w_col = write_col;
            w_sel = sel_src;
         end
         if (err_dim) e_cyc = c;
         if (grant_man || grant_rnd) begin
            g_cyc = c;
            g_man = grant_man;
            g_rnd = grant_rnd;
            break;
         end
      end
   endtask

   // Compare one finished transaction against the model, then advance it.
   task automatic check_txn(input int src, input int r, input int c);
      int exp_t;
      bit legal;
      legal = (r >= 1 && r <= 5 && c >= 1 && c <= 5);
      chk("grant_rnd_src", g_rnd, (src == 1) ? 1 : 0);
      chk("grant_man_src", g_man, (src == 0) ? 1 : 0);
      if (!legal) begin
         chk("err_cycle", e_cyc, 1);
         chk("err_grant_cycle", g_cyc, 1);
         chk("err_no_write", w_cyc, -1);
      end else begin
         exp_t = model_target(r, c);
         chk("wr_cycle", w_cyc, 2);
         chk("grant_cycle", g_cyc, 3);
         chk("no_err", e_cyc, -1);
         chk("target", w_tgt, exp_t);
         chk("write_row", w_row, r);
         chk("write_col", w_col, c);
         chk("sel_src", w_sel, src);
         model_write(exp_t, r, c);
      end
      m_last = src;
      q_row = r[2:0];
      q_col = c[2:0];
      #1;
      chk("q_cnt", q_cnt, model_cnt(r, c));
      chk("full", full, model_full());
   endtask

   // Raise the selected requests and serve them until both are granted.
   task automatic serve(input bit use_man, input bit use_rnd,
                        input int mr, input int mc, input int rr, input int rc);
      int src;
      @(negedge clk);
      man_row = mr[2:0];
      man_col = mc[2:0];
      rnd_row = rr[2:0];
      rnd_col = rc[2:0];
      req_man = use_man;
      req_rnd = use_rnd;
      for (int k = 0; k < 2 && (req_man || req_rnd); k++) begin
         if (req_man && req_rnd) src = (m_last == 0) ? 1 : 0;
         else src = req_rnd ? 1 : 0;
         watch(1);
         if (src == 1) check_txn(1, rr, rc);
         else check_txn(0, mr, mc);
         if (g_cyc < 0) begin
            req_man = 1'b0;
            req_rnd = 1'b0;
         end else if (g_rnd) begin
            req_rnd = 1'b0;
            grant_log.push_back(1);
         end else begin
            req_man = 1'b0;
            grant_log.push_back(0);
         end
         @(posedge clk);
      end
   endtask

   initial begin
      int mode, r, c;

      // rst src row col err tgt cnt full
      tbl[0]  = '{1'b1, 1'b0, 2, 3, 1'b0, 0, 1, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 2, 2, 1'b0, 0, 1, 1'b0};
      tbl[2]  = '{1'b0, 1'b0, 2, 2, 1'b0, 1, 2, 1'b0};
      tbl[3]  = '{1'b0, 1'b0, 2, 2, 1'b0, 2, 3, 1'b0};
      tbl[4]  = '{1'b0, 1'b0, 2, 2, 1'b0, 3, 4, 1'b0};
      tbl[5]  = '{1'b0, 1'b1, 2, 2, 1'b0, 0, 4, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 1, 1, 1'b0, 0, 1, 1'b0};
      tbl[7]  = '{1'b0, 1'b1, 1, 2, 1'b0, 1, 1, 1'b0};
      tbl[8]  = '{1'b0, 1'b0, 1, 3, 1'b0, 2, 1, 1'b0};
      tbl[9]  = '{1'b0, 1'b1, 2, 1, 1'b0, 3, 1, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 2, 2, 1'b0, 4, 1, 1'b0};
      tbl[11] = '{1'b0, 1'b1, 2, 3, 1'b0, 5, 1, 1'b0};
      tbl[12] = '{1'b0, 1'b0, 3, 1, 1'b0, 6, 1, 1'b0};
      tbl[13] = '{1'b0, 1'b1, 3, 2, 1'b0, 7, 1, 1'b1};
      tbl[14] = '{1'b0, 1'b0, 3, 3, 1'b0, 0, 1, 1'b1};
      tbl[15] = '{1'b0, 1'b1, 6, 2, 1'b1, 0, 0, 1'b1};
      tbl[16] = '{1'b0, 1'b0, 0, 3, 1'b1, 0, 0, 1'b1};
      tbl[17] = '{1'b0, 1'b1, 5, 5, 1'b0, 1, 1, 1'b1};

      // Directed vector table
      for (int v = 0; v < 18; v++) begin
         if (tbl[v].rst) do_reset();
         serve(!tbl[v].src, tbl[v].src, tbl[v].row, tbl[v].col, tbl[v].row, tbl[v].col);
         chk("tbl_err", (e_cyc >= 0) ? 1 : 0, tbl[v].exp_err);
         if (!tbl[v].exp_err) chk("tbl_target", w_tgt, tbl[v].exp_tgt);
         q_row = tbl[v].row[2:0];
         q_col = tbl[v].col[2:0];
         #1;
         chk("tbl_q_cnt", q_cnt, tbl[v].exp_cnt);
         chk("tbl_full", full, tbl[v].exp_full);
      end
      // The 1x1 matrix in slot 0 was evicted by the 3x3 write.
      q_row = 3'd1;
      q_col = 3'd1;
      #1;
      chk("evicted_scale_cnt", q_cnt, 0);

      // Simultaneous requests twice in a row: manual first, then random.
      do_reset();
      grant_log.delete();
      serve(1'b1, 1'b1, 1, 1, 4, 4);
      serve(1'b1, 1'b1, 2, 2, 3, 3);
      chk("arb_log_size", grant_log.size(), 4);
      if (grant_log.size() == 4) begin
         chk("arb_first", grant_log[0], 0);
         chk("arb_second", grant_log[1], 1);
         chk("arb_third", grant_log[2], 0);
         chk("arb_fourth", grant_log[3], 1);
      end

      // Inputs changing after the request is latched must not matter.
      @(negedge clk);
      man_row = 3'd4;
      man_col = 3'd4;
      req_man = 1'b1;
      @(posedge clk);
      #1;
      chk("busy_alloc", busy, 1);
      chk("state_alloc", dbg_state, 1);
      man_row = 3'd1;
      man_col = 3'd5;
      watch(2);
      check_txn(0, 4, 4);
      req_man = 1'b0;
      @(posedge clk);
      #1;
      chk("busy_idle", busy, 0);

      // Fill the store, then reset in the middle of a write.
      serve(1'b1, 1'b0, 5, 1, 0, 0);
      serve(1'b0, 1'b1, 0, 0, 5, 2);
      serve(1'b1, 1'b0, 5, 3, 0, 0);
      @(negedge clk);
      man_row = 3'd2;
      man_col = 3'd2;
      req_man = 1'b1;
      q_row   = 3'd2;
      q_col   = 3'd2;
      repeat (2) @(posedge clk);
      #1;
      chk("wr_before_rst", wr_en, 1);
      chk("q_cnt_before_rst", q_cnt, model_cnt(2, 2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_wr_en", wr_en, 0);
      chk("rst_mid_q_cnt", q_cnt, 0);
      chk("rst_mid_full", full, 0);
      chk("rst_mid_busy", busy, 0);
      req_man = 1'b0;
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;
      serve(1'b0, 1'b1, 0, 0, 3, 4);
      chk("post_rst_target", w_tgt, 0);

      // Randomized traffic against the model
      do_reset();
      for (int n = 0; n < 90; n++) begin
         mode = $urandom_range(0, 2);
         r = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 3);
         c = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 7) : $urandom_range(1, 2);
         if (mode == 2)
            serve(1'b1, 1'b1, r, c, $urandom_range(1, 3), $urandom_range(1, 2));
         else
            serve(mode == 0, mode == 1, r, c, r, c);
         q_row = 3'($urandom_range(0, 7));
         q_col = 3'($urandom_range(0, 7));
         #1;
         chk("rand_q_cnt", q_cnt, model_cnt(q_row, q_col));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
